// File: rtl/inst_rom_loader_if.sv
// Fetch and byte-load signal bundle for inst_rom_loader.
// Signal names are given from the loader's point of view (_i into the loader, _o out of it).
interface inst_rom_loader_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  ce_i;
    logic [31:0]           addr_i;
    logic [31:0]           inst_o;
    logic                  ld_start_i;
    logic                  ld_valid_i;
    logic [7:0]            ld_byte_i;
    logic                  ld_end_i;
    logic                  ld_ready_o;
    logic [DEPTH_LOG2:0]   word_cnt_o;

    modport master (
        output ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_end_i,
        input  inst_o, ld_ready_o, word_cnt_o
    );

    modport slave (
        input  ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_end_i,
        output inst_o, ld_ready_o, word_cnt_o
    );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction memory with a byte-serial loader. Holds the core in reset until an
// image has been loaded (or the memory fills), then serves combinational fetches.
//
// state   | meaning
// IDLE    | no image loaded since reset, core held in reset
// LOAD    | accepting big-endian bytes into memory, core held in reset
// RUN     | image complete, core running and fetching
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10,
    parameter bit AUTO_RUN   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    inst_rom_loader_if.slave   bus,
    output logic               cpu_rst_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2:0]     ptr_q, ptr_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [23:0]             asm_q, asm_d;

    logic [31:0]             mem [DEPTH];
    logic                    we;
    logic [DEPTH_LOG2-1:0]   waddr;
    logic [31:0]             wdata;
    logic                    accept;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^bus.addr_i[1:0];

    // ptr never exceeds DEPTH, so its top bit alone marks the memory as full
    assign bus.ld_ready_o = (state_q == ST_LOAD) && !ptr_q[DEPTH_LOG2];
    assign accept         = bus.ld_ready_o && bus.ld_valid_i;
    assign bus.word_cnt_o = ptr_q;
    assign cpu_rst_o      = rst || (state_q != ST_RUN);
    assign waddr          = ptr_q[DEPTH_LOG2-1:0];

    // Next-state, byte assembly and the single memory write port
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        we         = 1'b0;
        wdata      = '0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus.ld_start_i) begin
                    state_d    = ST_LOAD;
                    ptr_d      = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                end
            end
            ST_LOAD: begin
                if (bus.ld_start_i) begin
                    ptr_d      = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                end else begin
                    if (accept) begin
                        if (byte_cnt_q == 2'd3) begin
                            we         = 1'b1;
                            wdata      = {asm_q, bus.ld_byte_i};
                            ptr_d      = ptr_q + 1'b1;
                            byte_cnt_d = '0;
                        end else begin
                            asm_d      = {asm_q[15:0], bus.ld_byte_i};
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                    // A partial word only exists when no full word was written this
                    // cycle, so the write port is never needed twice.
                    if (bus.ld_end_i) begin
                        state_d = ST_RUN;
                        if (byte_cnt_d != 2'd0) begin
                            we    = 1'b1;
                            ptr_d = ptr_q + 1'b1;
                            case (byte_cnt_d)
                                2'd1:    wdata = {asm_d[7:0], 24'h0};
                                2'd2:    wdata = {asm_d[15:0], 16'h0};
                                default: wdata = {asm_d, 8'h0};
                            endcase
                            byte_cnt_d = '0;
                        end
                    end
                    if (ptr_d[DEPTH_LOG2]) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= AUTO_RUN ? ST_RUN : ST_IDLE;
            ptr_q      <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
        end
    end

    // Memory contents survive reset; a reset cycle only suppresses the write
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational fetch, NOP outside the memory or while the core is not running
    always_comb begin
        bus.inst_o = '0;
        if (bus.ce_i && (state_q == ST_RUN) && (bus.addr_i[31:DEPTH_LOG2+2] == '0)) begin
            bus.inst_o = mem[bus.addr_i[DEPTH_LOG2+1:2]];
        end
    end
endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: directed scenarios plus randomized loads checked
// against an image model built from the byte stream.
module tb_inst_rom_loader;
    localparam int DL2 = 2;

    logic clk;
    logic rst;
    logic cpu_rst;
    logic cpu_rst_ar;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [4];
    bit          m_known [4];
    int          m_wc;

    inst_rom_loader_if #(.DEPTH_LOG2(DL2)) bus ();
    inst_rom_loader_if #(.DEPTH_LOG2(DL2)) bus_ar ();

    inst_rom_loader #(.DEPTH_LOG2(DL2), .AUTO_RUN(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .cpu_rst_o (cpu_rst)
    );

    inst_rom_loader #(.DEPTH_LOG2(DL2), .AUTO_RUN(1'b1)) dut_ar (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_ar.slave),
        .cpu_rst_o (cpu_rst_ar)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b0;
        bus.ld_end_i   = 1'b0;
        bus.ld_byte_i  = 8'h00;
    endtask

    // Expected image: accepted bytes packed big-endian, last word zero padded
    task automatic model_load(input logic [7:0] q[$]);
        int n;
        logic [31:0] word;
        n = (q.size() > 16) ? 16 : q.size();
        m_wc = (n + 3) / 4;
        for (int w = 0; w < m_wc; w++) begin
            word = '0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < n) word[31 - 8 * b -: 8] = q[4 * w + b];
            end
            m_mem[w]   = word;
            m_known[w] = 1'b1;
        end
    endtask

    task automatic drive_load(input logic [7:0] q[$], input bit end_last, input bit gaps);
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.ld_valid_i = 1'b0;
                tick();
            end
            bus.ld_valid_i = 1'b1;
            bus.ld_byte_i  = q[i];
            bus.ld_end_i   = end_last && (i == q.size() - 1);
            tick();
        end
        bus.ld_valid_i = 1'b0;
        bus.ld_end_i   = 1'b0;
        if (!end_last || q.size() == 0) begin
            bus.ld_end_i = 1'b1;
            tick();
            bus.ld_end_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.ce_i   = 1'b1;
        bus.addr_i = 32'h0;
        tick();
        tick();
        checks++;
        if (cpu_rst_ar !== 1'b1) begin
            errors++; $display("FAIL reset_ar_hold: got %b want 1", cpu_rst_ar);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
        checks++;
        if (bus.inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", bus.inst_o); end
        checks++;
        if (bus.word_cnt_o !== 3'd0) begin errors++; $display("FAIL reset_wc: got %0d want 0", bus.word_cnt_o); end
        checks++;
        if (bus.ld_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.ld_ready_o); end
        checks++;
        if (cpu_rst_ar !== 1'b0) begin errors++; $display("FAIL reset_autorun: got %b want 0", cpu_rst_ar); end
        checks++;
        if (bus_ar.ld_ready_o !== 1'b0) begin
            errors++; $display("FAIL reset_autorun_ready: got %b want 0", bus_ar.ld_ready_o);
        end
        // bytes and end in IDLE are ignored
        bus.ld_valid_i = 1'b1;
        bus.ld_byte_i  = 8'h5A;
        bus.ld_end_i   = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.word_cnt_o !== 3'd0 || cpu_rst !== 1'b1) begin
            errors++; $display("FAIL idle_ignore: wc %0d cpu_rst %b want 0/1", bus.word_cnt_o, cpu_rst);
        end
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        q = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
        drive_load(q, 1'b0, 1'b0);
        model_load(q);
        checks++;
        if (bus.word_cnt_o !== 3'd2) begin errors++; $display("FAIL basic_wc: got %0d want 2", bus.word_cnt_o); end
        checks++;
        if (cpu_rst !== 1'b0) begin errors++; $display("FAIL basic_cpu_rst: got %b want 0", cpu_rst); end
        bus.ce_i = 1'b1; bus.addr_i = 32'h0; #1;
        checks++;
        if (bus.inst_o !== 32'h34011100) begin errors++; $display("FAIL basic_w0: got %h want 34011100", bus.inst_o); end
        bus.addr_i = 32'h4; #1;
        checks++;
        if (bus.inst_o !== 32'h34020020) begin errors++; $display("FAIL basic_w1: got %h want 34020020", bus.inst_o); end
        bus.addr_i = 32'h7; #1;
        checks++;
        if (bus.inst_o !== 32'h34020020) begin errors++; $display("FAIL basic_lowbits: got %h want 34020020", bus.inst_o); end
        bus.ce_i = 1'b0; #1;
        checks++;
        if (bus.inst_o !== 32'h0) begin errors++; $display("FAIL basic_ce_off: got %h want 0", bus.inst_o); end
        bus.ce_i = 1'b1;
    endtask

    task automatic test_partial();
        logic [7:0] q[$];
        q = '{8'hAA, 8'hBB};
        drive_load(q, 1'b1, 1'b0);
        model_load(q);
        bus.addr_i = 32'h0; #1;
        checks++;
        if (bus.inst_o !== 32'hAABB0000) begin errors++; $display("FAIL partial_w0: got %h want aabb0000", bus.inst_o); end
        checks++;
        if (bus.word_cnt_o !== 3'd1) begin errors++; $display("FAIL partial_wc: got %0d want 1", bus.word_cnt_o); end
    endtask

    task automatic test_fill();
        logic [7:0] q[$];
        for (int i = 0; i < 16; i++) q.push_back(8'(8'h10 + i));
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.ld_valid_i = 1'b1;
            bus.ld_byte_i  = q[i];
            tick();
        end
        bus.ld_valid_i = 1'b0;
        model_load(q);
        checks++;
        if (bus.ld_ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b want 0", bus.ld_ready_o); end
        checks++;
        if (cpu_rst !== 1'b0) begin errors++; $display("FAIL fill_autorun: got %b want 0", cpu_rst); end
        checks++;
        if (bus.word_cnt_o !== 3'd4) begin errors++; $display("FAIL fill_wc: got %0d want 4", bus.word_cnt_o); end
        bus.ld_valid_i = 1'b1;
        bus.ld_byte_i  = 8'hEE;
        bus.ld_end_i   = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.word_cnt_o !== 3'd4) begin errors++; $display("FAIL fill_17th_wc: got %0d want 4", bus.word_cnt_o); end
        bus.addr_i = 32'h0; #1;
        checks++;
        if (bus.inst_o !== 32'h10111213) begin errors++; $display("FAIL fill_w0: got %h want 10111213", bus.inst_o); end
        bus.addr_i = 32'hC; #1;
        checks++;
        if (bus.inst_o !== 32'h1C1D1E1F) begin errors++; $display("FAIL fill_w3: got %h want 1c1d1e1f", bus.inst_o); end
        bus.addr_i = 32'h10; #1;
        checks++;
        if (bus.inst_o !== 32'h0) begin errors++; $display("FAIL fill_oor: got %h want 0", bus.inst_o); end
    endtask

    task automatic test_restart();
        logic [7:0] q[$];
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b1;
        bus.ld_byte_i  = 8'hDE; tick();
        bus.ld_byte_i  = 8'hAD; tick();
        // restart wins over a byte in the same cycle
        bus.ld_start_i = 1'b1;
        bus.ld_byte_i  = 8'h99; tick();
        bus.ld_start_i = 1'b0;
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            bus.ld_byte_i = q[i];
            tick();
        end
        bus.ld_valid_i = 1'b0;
        bus.ld_end_i   = 1'b1;
        tick();
        idle_inputs();
        model_load(q);
        bus.addr_i = 32'h0; #1;
        checks++;
        if (bus.inst_o !== 32'h11223344) begin errors++; $display("FAIL restart_w0: got %h want 11223344", bus.inst_o); end
        checks++;
        if (bus.word_cnt_o !== 3'd1) begin errors++; $display("FAIL restart_wc: got %0d want 1", bus.word_cnt_o); end
        checks++;
        if (cpu_rst !== 1'b0) begin errors++; $display("FAIL restart_cpu_rst: got %b want 0", cpu_rst); end
    endtask

    task automatic test_reset_midload();
        logic [7:0] q[$];
        q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55};
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.ld_valid_i = 1'b1;
            bus.ld_byte_i  = q[i];
            tick();
        end
        bus.ld_valid_i = 1'b0;
        void'(q.pop_back());
        model_load(q);
        rst = 1'b1;
        tick();
        checks++;
        if (bus.word_cnt_o !== 3'd0) begin errors++; $display("FAIL midrst_wc: got %0d want 0", bus.word_cnt_o); end
        checks++;
        if (cpu_rst !== 1'b1) begin errors++; $display("FAIL midrst_cpu_rst: got %b want 1", cpu_rst); end
        rst = 1'b0;
        tick();
        checks++;
        if (cpu_rst !== 1'b1 || bus.ld_ready_o !== 1'b0) begin
            errors++; $display("FAIL midrst_idle: cpu_rst %b ready %b want 1/0", cpu_rst, bus.ld_ready_o);
        end
        // empty load just to reach RUN and inspect retained contents
        bus.ld_start_i = 1'b1; tick();
        bus.ld_start_i = 1'b0;
        bus.ld_end_i   = 1'b1; tick();
        bus.ld_end_i   = 1'b0;
        m_wc = 0;
        bus.ce_i = 1'b1; bus.addr_i = 32'h0; #1;
        checks++;
        if (bus.inst_o !== 32'hDEADBEEF) begin errors++; $display("FAIL midrst_retain: got %h want deadbeef", bus.inst_o); end
        checks++;
        if (bus.word_cnt_o !== 3'd0) begin errors++; $display("FAIL empty_wc: got %0d want 0", bus.word_cnt_o); end
        bus.ce_i = 1'b0; #1;
        checks++;
        if (bus.inst_o !== 32'h0) begin errors++; $display("FAIL run_ce_off: got %h want 0", bus.inst_o); end
        bus.ce_i = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int n;
        int acc;
        bit end_last;
        logic [31:0] a;
        for (int it = 0; it < 30; it++) begin
            q.delete();
            n = $urandom_range(0, 19);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            end_last = 1'($urandom_range(0, 1));
            bus.ld_start_i = 1'b1;
            tick();
            bus.ld_start_i = 1'b0;
            acc = 0;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.ld_valid_i = 1'b0;
                    tick();
                end
                bus.ld_valid_i = 1'b1;
                bus.ld_byte_i  = q[i];
                bus.ld_end_i   = end_last && (i == n - 1);
                #1;
                checks++;
                if (bus.ld_ready_o !== (acc < 16)) begin
                    errors++; $display("FAIL rnd_ready it%0d byte%0d: got %b want %b", it, i, bus.ld_ready_o, acc < 16);
                end
                tick();
                if (acc < 16) acc++;
            end
            bus.ld_valid_i = 1'b0;
            bus.ld_end_i   = 1'b0;
            if (!end_last || n == 0) begin
                bus.ld_end_i = 1'b1;
                tick();
                bus.ld_end_i = 1'b0;
            end
            model_load(q);
            checks++;
            if (bus.word_cnt_o !== 3'(m_wc)) begin
                errors++; $display("FAIL rnd_wc it%0d: got %0d want %0d", it, bus.word_cnt_o, m_wc);
            end
            checks++;
            if (cpu_rst !== 1'b0 || bus.ld_ready_o !== 1'b0) begin
                errors++; $display("FAIL rnd_run it%0d: cpu_rst %b ready %b want 0/0", it, cpu_rst, bus.ld_ready_o);
            end
            bus.ce_i = 1'b1;
            for (int w = 0; w < 4; w++) begin
                if (m_known[w]) begin
                    bus.addr_i = {28'h0, 2'(w), 2'($urandom)};
                    #1;
                    checks++;
                    if (bus.inst_o !== m_mem[w]) begin
                        errors++; $display("FAIL rnd_word it%0d w%0d: got %h want %h", it, w, bus.inst_o, m_mem[w]);
                    end
                end
            end
            a = $urandom;
            if (a[31:4] == 28'h0) a[4] = 1'b1;
            bus.addr_i = a;
            #1;
            checks++;
            if (bus.inst_o !== 32'h0) begin
                errors++; $display("FAIL rnd_oor it%0d addr %h: got %h want 0", it, a, bus.inst_o);
            end
        end
    endtask

    initial begin
        bus.ce_i = 1'b0;
        bus.addr_i = 32'h0;
        bus_ar.ce_i = 1'b0;
        bus_ar.addr_i = 32'h0;
        bus_ar.ld_start_i = 1'b0;
        bus_ar.ld_valid_i = 1'b0;
        bus_ar.ld_byte_i = 8'h00;
        bus_ar.ld_end_i = 1'b0;
        for (int w = 0; w < 4; w++) m_known[w] = 1'b0;
        m_wc = 0;
        test_reset();
        test_basic();
        test_partial();
        test_fill();
        test_restart();
        test_reset_midload();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
